// File: rtl/uart_arb_pkg.sv
// Shared state encoding, UART timing constants and helpers for the UART TX arbiter.
package uart_arb_pkg;

  localparam int CLK_HZ        = 12_000_000;
  localparam int BAUD          = 9600;
  localparam int CLKS_PER_BIT  = CLK_HZ / BAUD;
  localparam int CLKS_PER_BYTE = CLKS_PER_BIT * 10;

  typedef enum logic [1:0] {
    IDLE,
    LOCK,
    WAIT_HI,
    WAIT_LO
  } arb_state_e;

  function automatic logic [2:0] wrap_inc(
    input logic [2:0] v,
    input int         n
  );
    return (int'(v) >= n - 1) ? 3'd0 : v + 3'd1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: first set request scanning upward from ptr, with wrap.
module uart_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] pick,
  output logic [2:0]      pick_id,
  output logic            any
);

  always_comb begin
    pick    = '0;
    pick_id = '0;
    any     = 1'b0;
    for (int o = 0; o < NREQ; o++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!any && req[j] && ((int'(ptr) + o) % NREQ == j)) begin
          any     = 1'b1;
          pick[j] = 1'b1;
          pick_id = 3'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one UART TX among NREQ byte sources.
// Optional idle-owner watchdog: define UART_ARB_WDOG_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int BUSY_LAT = 2,
  parameter int WDOG_CYC = 2 * CLKS_PER_BYTE
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_last,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    grant,
  output logic [2:0]         grant_id,
  output logic               tx_start,
  output logic [DW-1:0]      tx_data,
  input  logic               tx_busy,
  output logic               wdog_err
);

  if (NREQ < 2 || NREQ > 8 || BUSY_LAT < 1 || BUSY_LAT > 255 ||
      WDOG_CYC < 2 || WDOG_CYC > 32767) begin : g_cfg_err
    $error("uart_tx_arbiter: parameter out of range");
  end

  arb_state_e      state;
  arb_state_e      state_nxt;
  logic [2:0]      rr_ptr;
  logic [NREQ-1:0] pick;
  logic [2:0]      pick_id;
  logic            pick_any;
  logic            own_valid;
  logic            own_last;
  logic [DW-1:0]   own_data;
  logic            last_q;
  logic [7:0]      hi_cnt;
  logic            accept;
  logic            take;
  logic            release_own;
  logic            wdog_fire;

  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (pick_any)
  );

  // grant is one-hot, so masking avoids a variable-width index
  assign own_valid = |(req_valid & grant);
  assign own_last  = |(req_last & grant);

  always_comb begin
    own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) own_data = own_data | req_data[i*DW +: DW];
    end
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    take        = 1'b0;
    release_own = 1'b0;
    req_ready   = '0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          take      = 1'b1;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        if (own_valid && !tx_busy) begin
          accept    = 1'b1;
          req_ready = grant;
          state_nxt = WAIT_HI;
        end else if (wdog_fire) begin
          release_own = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WAIT_HI: begin
        if (tx_busy || hi_cnt == 8'(BUSY_LAT - 1)) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q) begin
            release_own = 1'b1;
            state_nxt   = IDLE;
          end else begin
            state_nxt = LOCK;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_ptr   <= '0;
      grant    <= '0;
      grant_id <= '0;
      last_q   <= 1'b0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      hi_cnt   <= '0;
      wdog_err <= 1'b0;
    end else begin
      tx_start <= accept;
      wdog_err <= wdog_fire;
      hi_cnt   <= (state == WAIT_HI) ? hi_cnt + 8'd1 : 8'd0;
      if (accept) begin
        tx_data <= own_data;
        last_q  <= own_last;
      end
      if (take) begin
        grant    <= pick;
        grant_id <= pick_id;
      end else if (release_own) begin
        grant  <= '0;
        rr_ptr <= wrap_inc(grant_id, NREQ);
      end
    end
  end

`ifdef UART_ARB_WDOG_EN
  logic [14:0] wdog_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wdog_cnt <= '0;
    end else if (state != LOCK || accept || wdog_fire) begin
      wdog_cnt <= '0;
    end else if (!own_valid) begin
      wdog_cnt <= wdog_cnt + 15'd1;
    end
  end

  assign wdog_fire = (state == LOCK) && !own_valid &&
                     (wdog_cnt == 15'(WDOG_CYC - 1));
`else
  assign wdog_fire = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, UART busy model, message-level order model.
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int UART_CYC = 40;

  logic           clk = 1'b0;
  logic           nrst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic [2:0]     grant_id;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           wdog_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ(N), .DW(8), .BUSY_LAT(2), .WDOG_CYC(100)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant     (grant),
    .grant_id  (grant_id),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .wdog_err  (wdog_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  logic [8:0] mem [N][64];
  int hd [N];
  int tl [N];
  int mptr;

  int         exp_q [$];
  int         obs_q [$];
  int         obs_t [$];
  logic [3:0] obs_g [$];

  logic uart_busy  = 1'b0;
  logic busy_force = 1'b0;
  int   uart_cnt   = 0;
  bit   start_seen = 0;
  bit   norise     = 0;
  int   ready_bad  = 0;
  int   wdog_pulses = 0;

  assign tx_busy = uart_busy | busy_force;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, input logic l);
    if (hd[i] == tl[i]) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    mem[i][tl[i]] = {l, b};
    tl[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (hd[i] < tl[i]) begin
        req_valid[i] = 1'b1;
        {req_last[i], req_data[i*8 +: 8]} = mem[i][hd[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'($urandom);
        req_data[i*8 +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic cyc();
    logic [N-1:0] rdy;
    @(negedge clk);
    rdy = req_ready;
    if ((rdy & ~grant) != '0 || $countones(rdy) > 1) ready_bad++;
    @(posedge clk);
    #1;
    cyc_n++;
    for (int i = 0; i < N; i++) begin
      if (rdy[i]) begin
        if (hd[i] < tl[i]) hd[i]++;
        else ready_bad++;
      end
    end
    if (uart_busy) begin
      uart_cnt--;
      if (uart_cnt == 0) uart_busy = 1'b0;
    end
    if (start_seen && !norise) begin
      uart_busy = 1'b1;
      uart_cnt  = UART_CYC;
    end
    start_seen = 0;
    if (wdog_err === 1'b1) wdog_pulses++;
    if (tx_start === 1'b1) begin
      obs_q.push_back(int'(grant_id) * 256 + int'(tx_data));
      obs_t.push_back(cyc_n);
      obs_g.push_back(grant);
      start_seen = 1;
    end
    drive();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (hd[i] < tl[i]) return 0;
    return 1;
  endfunction

  // Whole-message round-robin order of everything currently queued.
  task automatic model();
    int h [N];
    int w;
    int j;
    logic [8:0] e;
    for (int i = 0; i < N; i++) h[i] = hd[i];
    forever begin
      w = -1;
      for (int o = 0; o < N; o++) begin
        j = (mptr + o) % N;
        if (w < 0 && h[j] < tl[j]) w = j;
      end
      if (w < 0) break;
      do begin
        e = mem[w][h[w]];
        exp_q.push_back(w * 256 + int'(e[7:0]));
        h[w]++;
      end while (!e[8] && h[w] < tl[w]);
      mptr = (w + 1) % N;
    end
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!(all_empty() && grant === '0 && !uart_busy) && n < budget);
    check({tag, " done"}, 32'(n < budget), 32'd1);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_t.delete();
    obs_g.delete();
    exp_q.delete();
  endtask

  task automatic compare(input string tag, input bit gapchk);
    int mg;
    check({tag, " count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
      check($sformatf("%s byte%0d", tag, k), 32'(obs_q[k]), 32'(exp_q[k]));
    if (gapchk && obs_t.size() > 1) begin
      mg = 1 << 30;
      for (int k = 1; k < obs_t.size(); k++)
        if (obs_t[k] - obs_t[k-1] < mg) mg = obs_t[k] - obs_t[k-1];
      check({tag, " spacing"}, 32'(mg >= UART_CYC), 32'd1);
    end
    check({tag, " ready"}, 32'(ready_bad), 32'd0);
    clear_obs();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check("rst grant", 32'(grant), 32'd0);
    check("rst grant_id", 32'(grant_id), 32'd0);
    check("rst tx_start", 32'(tx_start), 32'd0);
    check("rst tx_data", 32'(tx_data), 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst wdog_err", 32'(wdog_err), 32'd0);
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    mptr = 0;
    drive();
    repeat (n) cyc();
    clear_obs();
    nrst = 1'b1;
  endtask

  initial begin
    int t0;
    int f;
    int n;
    int nmsg;
    int len;
    logic [7:0] spec_msg [4];
    spec_msg[0] = 8'h53;
    spec_msg[1] = 8'h6E;
    spec_msg[2] = 8'h61;
    spec_msg[3] = 8'h70;
    nrst = 1'b1;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    mptr = 0;
    drive();
    do_reset(4);

    // single 4-byte message from req0
    for (int k = 0; k < 4; k++) push(0, spec_msg[k], k == 3);
    model();
    t0 = cyc_n;
    drive();
    run_idle("single", 1000);
    if (obs_t.size() > 0) check("single latency", 32'(obs_t[0] - t0), 32'd2);
    for (int k = 0; k < obs_g.size(); k++)
      check($sformatf("single grant%0d", k), 32'(obs_g[k]), 32'b0001);
    compare("single", 1);

    // pointer moved past req0: req1 must win a tie with req0
    push(0, 8'($urandom), 1'b1);
    push(1, 8'($urandom), 1'b1);
    model();
    drive();
    run_idle("ptr", 1000);
    compare("ptr", 1);

    // four-way contention from reset, then req0/req2 re-request
    do_reset(3);
    for (int i = 0; i < N; i++) push(i, 8'(8'hA0 + i), 1'b1);
    model();
    drive();
    run_idle("contend", 2000);
    compare("contend", 1);
    push(0, 8'($urandom), 1'b1);
    push(2, 8'($urandom), 1'b1);
    model();
    drive();
    run_idle("rerequest", 1000);
    compare("rerequest", 1);

    // 3-byte message from req1 while req2 waits
    do_reset(3);
    for (int k = 0; k < 3; k++) push(1, 8'($urandom), k == 2);
    push(2, 8'($urandom), 1'b1);
    model();
    drive();
    run_idle("nointerleave", 2000);
    compare("nointerleave", 1);

    // random message mixes
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) begin
        nmsg = int'($urandom_range(0, 2));
        for (int m = 0; m < nmsg; m++) begin
          len = int'($urandom_range(1, 3));
          for (int k = 0; k < len; k++) push(i, 8'($urandom), k == len - 1);
        end
      end
      model();
      drive();
      run_idle($sformatf("rand%0d", r), 6000);
      compare($sformatf("rand%0d", r), 1);
    end

    // busy held externally, then a UART whose busy never rises
    norise = 1;
    busy_force = 1'b1;
    push(3, 8'($urandom), 1'b0);
    push(3, 8'($urandom), 1'b1);
    model();
    drive();
    repeat (500) cyc();
    check("busy nostart", 32'(obs_q.size()), 32'd0);
    busy_force = 1'b0;
    f = cyc_n;
    run_idle("busy", 1000);
    if (obs_t.size() > 1) begin
      check("busy first", 32'(obs_t[0]), 32'(f + 1));
      check("norise gap", 32'(obs_t[1] - obs_t[0]), 32'd4);
    end
    compare("busy", 0);
    norise = 0;

    // reset while waiting for busy to fall
    push(0, 8'($urandom), 1'b0);
    push(0, 8'($urandom), 1'b1);
    drive();
    n = 0;
    while (obs_q.size() == 0 && n < 50) begin
      cyc();
      n++;
    end
    check("midrst start", 32'(obs_q.size()), 32'd1);
    repeat (5) cyc();
    do_reset(10);
    push(2, 8'($urandom), 1'b1);
    model();
    drive();
    n = 0;
    while (uart_busy && n < 200) begin
      cyc();
      n++;
    end
    f = cyc_n;
    run_idle("midrst", 1000);
    if (obs_t.size() > 0) check("midrst first", 32'(obs_t[0]), 32'(f + 1));
    compare("midrst", 1);

    // owner stalls mid-message
    do_reset(3);
    push(1, 8'h11, 1'b0);
    drive();
    n = 0;
    while (hd[1] < tl[1] && n < 20) begin
      cyc();
      n++;
    end
    push(0, 8'h22, 1'b1);
    drive();
`ifdef UART_ARB_WDOG_EN
    n = 0;
    while (wdog_pulses == 0 && n < 400) begin
      cyc();
      n++;
    end
    check("wdog pulse", 32'(wdog_pulses), 32'd1);
    check("wdog grant", 32'(grant), 32'd0);
    exp_q.push_back(1 * 256 + 8'h11);
    exp_q.push_back(0 * 256 + 8'h22);
    run_idle("wdog", 1000);
    compare("wdog", 1);
`else
    repeat (300) cyc();
    check("hold grant", 32'(grant), 32'b0010);
    check("hold wdog", 32'(wdog_pulses), 32'd0);
    check("hold count", 32'(obs_q.size()), 32'd1);
    do_reset(3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
